shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//   Sequencer for the 8-bit serial shift datapath. Accepts a parallel word over a
//   valid/ready handshake and shifts it out on sdo at a programmable bit rate.
//   Simultaneously captures sdi into a receive word (full duplex).
//   Sits between the parallel register/bus side and the serial shift-register line.
// PARAMETERS
//   WIDTH      8   bits per transfer (>=2)
//   DIV        4   clk cycles per bit period (>=1; DIV=1 shifts every cycle)
//   MSB_FIRST  1   1: tx_data[WIDTH-1] sent first, rx fills from LSB; 0: mirror image
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   tx_data   in   WIDTH  word to transmit; sampled on handshake
//   tx_valid  in   1      tx_data valid
//   tx_ready  out  1      controller can accept a word (IDLE only)
//   sdo       out  1      serial data out (registered)
//   sdi       in   1      serial data in, synchronous to clk
//   shift_en  out  1      1-cycle strobe at the end of each bit period (sdi sample point)
//   busy      out  1      high in LOAD/SHIFT/DONE
//   rx_data   out  WIDTH  last fully received word; holds until next DONE
//   rx_valid  out  1      1-cycle pulse when rx_data updates
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, tx_ready=1, sdo=0, shift_en=0, busy=0,
//     rx_data=0, rx_valid=0, div_cnt=0, bit_cnt=0; any transfer in flight is dropped.
//   FSM: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
//   IDLE:  tx_ready=1. On tx_valid & tx_ready (cycle 0), capture tx_data; go to LOAD.
//   LOAD:  one cycle; load tx shift reg, drive sdo = first bit, clear div_cnt/bit_cnt.
//   SHIFT: div_cnt counts 0..DIV-1. At div_cnt==DIV-1: shift_en=1, sample sdi into
//          the rx shift reg, advance the tx shift reg (next bit on sdo the next cycle),
//          bit_cnt++, div_cnt wraps to 0. Each bit is held on sdo for exactly DIV cycles.
//          After the WIDTH-th strobe, go to DONE.
//   DONE:  one cycle; rx_data <= rx shift reg; rx_valid=1; sdo returns to 0. Go to IDLE.
//   Latency: handshake at cycle 0; first bit on sdo at cycle 2.
//     Last strobe at cycle 1+WIDTH*DIV; rx_valid at cycle 2+WIDTH*DIV.
//     tx_ready is high again at cycle 3+WIDTH*DIV. Back-to-back words: period 3+WIDTH*DIV.
//   tx_ready is low outside IDLE; tx_valid is ignored there (no queueing, no overwrite).
//   tx_valid may deassert without a handshake while tx_ready=0 (no protocol error).
//   bit_cnt width = clog2(WIDTH+1); div_cnt width = clog2(DIV), minimum 1 bit.
//   DIV=1: shift_en stays high for all WIDTH SHIFT cycles.
//   Reset mid-SHIFT: rx_valid is not produced; rx_data keeps its reset value 0.
//   No combinational path from any input to any output.
// STRUCTURE
//   Shared package/include shift_ctrl_defs: state encodings (IDLE=2'd0, LOAD=2'd1,
//     SHIFT=2'd2, DONE=2'd3) and the clog2 helper function.
//   Sub-module shift_bit_timer: div_cnt plus the shift_en strobe generator, with
//     ports (clk, rst, run, strobe). Top level holds the FSM, bit_cnt and both shift regs.
// TESTING
//   1 Reset idle: hold rst 3 cycles, release -> tx_ready=1, busy=0, sdo=0, rx_data=8'h00.
//   2 Loopback, DIV=4, MSB_FIRST=1: sdi tied to sdo, send 8'hA5 ->
//     sdo = 1,0,1,0,0,1,0,1, 4 cycles each; rx_valid at cycle 34; rx_data=8'hA5.
//   3 Back-to-back 8'h3C then 8'hC3 with tx_valid held high ->
//     second handshake exactly 35 cycles after the first; both words received intact.
//   4 tx_valid toggled during SHIFT with a different tx_data ->
//     no accept, in-flight word unaffected, tx_ready=0 until IDLE.
//   5 Assert rst at bit 4 of 8'hFF ->
//     sdo=0 and tx_ready=1 immediately; no rx_valid; next word 8'h01 transfers correctly.
//   6 DIV=1, MSB_FIRST=0, sdi=const 1, send 8'h01 ->
//     sdo = 1 then 0 x7, shift_en high 8 consecutive cycles; rx_data=8'hFF.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the serial shift sequencer: FSM state encodings and
// an elaboration-time ceil(log2) helper used to size the counters.
package shift_ctrl_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_bit_timer.sv
// Bit-period timer: counts DIV clocks while running and flags the last clock
// of each period, which is where the line is sampled and the next bit launched.
module shift_bit_timer
    import shift_ctrl_defs::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic strobe
);

    localparam int DW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] ONE  = DW'(1);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    // Counter held at zero whenever the sequencer is not shifting.
    always_comb begin
        div_cnt_d = '0;
        if (run) begin
            if (div_cnt_q == LAST) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + ONE;
            end
        end else begin
            div_cnt_d = '0;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign strobe = run && (div_cnt_q == LAST);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Full-duplex serial shift sequencer: takes a parallel word by valid/ready,
// shifts it out on sdo at one bit per DIV clocks and captures sdi in parallel.
module shift_seq_ctrl
    import shift_ctrl_defs::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sdo,
    input  logic             sdi,
    output logic             shift_en,
    output logic             busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
);

    localparam int BW = clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [BW-1:0] ONE      = BW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             sdo_q, sdo_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             run_s;
    logic             strobe_s;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[WIDTH-1];
        end else begin
            return w[0];
        end
    endfunction

    function automatic logic [WIDTH-1:0] tx_advance(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return {w[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, w[WIDTH-1:1]};
        end
    endfunction

    // Receive word fills from the opposite end to the transmit order.
    function automatic logic [WIDTH-1:0] rx_capture(input logic [WIDTH-1:0] w, input logic b);
        if (MSB_FIRST) begin
            return {w[WIDTH-2:0], b};
        end else begin
            return {b, w[WIDTH-1:1]};
        end
    endfunction

    assign run_s = (state_q == ST_SHIFT);

    shift_bit_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (run_s),
        .strobe (strobe_s)
    );

    // Next-state logic; rx_data/rx_valid are set on the final strobe so they
    // are visible during the DONE cycle.
    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        bit_cnt_d  = bit_cnt_q;
        sdo_d      = sdo_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    tx_sr_d = tx_data;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                sdo_d     = head_bit(tx_sr_q);
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (strobe_s) begin
                    tx_sr_d   = tx_advance(tx_sr_q);
                    rx_sr_d   = rx_capture(rx_sr_q, sdi);
                    bit_cnt_d = bit_cnt_q + ONE;
                    if (bit_cnt_q == LAST_BIT) begin
                        sdo_d      = 1'b0;
                        rx_data_d  = rx_sr_d;
                        rx_valid_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        sdo_d = head_bit(tx_sr_d);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                sdo_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            bit_cnt_q  <= '0;
            sdo_q      <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            sdo_q      <= sdo_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign shift_en = strobe_s;
    assign sdo      = sdo_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench: instance A (DIV=4, MSB first, sdi looped to sdo) and
// instance B (DIV=1, LSB first, sdi tied high).
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_valid_a, tx_valid_b;
    logic       tx_ready_a, tx_ready_b;
    logic       sdo_a, sdo_b;
    logic       sdi_a, sdi_b;
    logic       shift_en_a, shift_en_b;
    logic       busy_a, busy_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b;

    int tests = 0;
    int fails = 0;
    logic [7:0] rx_q[$];

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx_exp;
        bit         disturb;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    assign sdi_a = sdo_a;
    assign sdi_b = 1'b1;

    shift_seq_ctrl #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .sdo(sdo_a), .sdi(sdi_a), .shift_en(shift_en_a),
        .busy(busy_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a)
    );

    shift_seq_ctrl #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .sdo(sdo_b), .sdi(sdi_b), .shift_en(shift_en_b),
        .busy(busy_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b)
    );

    always @(posedge clk) begin
        if (rx_valid_a) rx_q.push_back(rx_data_a);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Full transfer on instance A, checked cycle by cycle from the handshake.
    task automatic xfer_a(input logic [7:0] w, input logic [7:0] exp, input bit disturb);
        logic [7:0] wv;
        wv = w;
        chk("idle_ready", 32'(tx_ready_a), 32'd1);
        tx_data_a  = w;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        chk("load_busy", 32'(busy_a), 32'd1);
        chk("load_ready", 32'(tx_ready_a), 32'd0);
        for (int b = 0; b < 8; b++) begin
            for (int d = 0; d < 4; d++) begin
                tx_valid_a = disturb & d[0];
                tx_data_a  = ~w;
                @(negedge clk);
                chk("sdo_bit", 32'(sdo_a), 32'(wv[7-b]));
                chk("shift_en", 32'(shift_en_a), 32'(d == 3));
                chk("shift_ready", 32'(tx_ready_a), 32'd0);
                chk("shift_rxv", 32'(rx_valid_a), 32'd0);
            end
        end
        tx_valid_a = 1'b0;
        @(negedge clk);
        chk("done_rxv", 32'(rx_valid_a), 32'd1);
        chk("done_rxd", 32'(rx_data_a), 32'(exp));
        chk("done_sdo", 32'(sdo_a), 32'd0);
        chk("done_ready", 32'(tx_ready_a), 32'd0);
        @(negedge clk);
        chk("post_ready", 32'(tx_ready_a), 32'd1);
        chk("post_busy", 32'(busy_a), 32'd0);
        chk("post_rxv", 32'(rx_valid_a), 32'd0);
        chk("post_rxd_hold", 32'(rx_data_a), 32'(exp));
    endtask

    initial begin
        int gap;
        vecs[0] = '{tx: 8'hA5, rx_exp: 8'hA5, disturb: 1'b0};
        vecs[1] = '{tx: 8'h00, rx_exp: 8'h00, disturb: 1'b0};
        vecs[2] = '{tx: 8'hFF, rx_exp: 8'hFF, disturb: 1'b0};
        vecs[3] = '{tx: 8'h96, rx_exp: 8'h96, disturb: 1'b1};
        vecs[4] = '{tx: 8'h5A, rx_exp: 8'h5A, disturb: 1'b1};

        rst_a = 1'b1; rst_b = 1'b1;
        tx_data_a = 8'h00; tx_valid_a = 1'b0;
        tx_data_b = 8'h00; tx_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("rst_ready_a", 32'(tx_ready_a), 32'd1);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_sdo_a", 32'(sdo_a), 32'd0);
        chk("rst_rxd_a", 32'(rx_data_a), 32'h00);
        chk("rst_ready_b", 32'(tx_ready_b), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd0);

        for (int i = 0; i < 5; i++) begin
            xfer_a(vecs[i].tx, vecs[i].rx_exp, vecs[i].disturb);
        end

        // Back-to-back with tx_valid held high
        rx_q.delete();
        tx_data_a  = 8'h3C;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_data_a = 8'hC3;
        gap = 1;
        while (!tx_ready_a && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b_gap", 32'(gap), 32'd35);
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (40) @(negedge clk);
        chk("b2b_count", 32'(rx_q.size()), 32'd2);
        chk("b2b_word0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'h3C);
        chk("b2b_word1", (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hFFFF_FFFF, 32'hC3);

        // Reset during bit 4 of 0xFF
        rx_q.delete();
        tx_data_a  = 8'hFF;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (17) @(negedge clk);
        chk("mid_sdo", 32'(sdo_a), 32'd1);
        chk("mid_busy", 32'(busy_a), 32'd1);
        rst_a = 1'b1;
        #1;
        chk("rst_now_sdo", 32'(sdo_a), 32'd0);
        chk("rst_now_ready", 32'(tx_ready_a), 32'd1);
        chk("rst_now_busy", 32'(busy_a), 32'd0);
        chk("rst_now_sen", 32'(shift_en_a), 32'd0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_no_rxv", 32'(rx_q.size()), 32'd0);
        chk("rst_rxd_zero", 32'(rx_data_a), 32'h00);
        xfer_a(8'h01, 8'h01, 1'b0);

        // DIV=1, LSB first, sdi constant 1
        tx_data_b  = 8'h01;
        tx_valid_b = 1'b1;
        @(negedge clk);
        tx_valid_b = 1'b0;
        chk("b_load_sen", 32'(shift_en_b), 32'd0);
        chk("b_load_busy", 32'(busy_b), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("b_sdo", 32'(sdo_b), (k == 0) ? 32'd1 : 32'd0);
            chk("b_sen", 32'(shift_en_b), 32'd1);
        end
        @(negedge clk);
        chk("b_rxv", 32'(rx_valid_b), 32'd1);
        chk("b_rxd", 32'(rx_data_b), 32'hFF);
        chk("b_done_sdo", 32'(sdo_b), 32'd0);
        chk("b_done_sen", 32'(shift_en_b), 32'd0);
        @(negedge clk);
        chk("b_ready", 32'(tx_ready_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
